// File: rtl/sram_ctrl.sv
// Single-port SRAM controller with byte enables, optional zero-fill after reset and 1- or 2-cycle reads.
// Latency: write commits at the accept edge; rsp_valid rises READ_LAT edges after a read is accepted.
// Backpressure: one read outstanding; req_ready is low outside IDLE and the response holds until rsp_ready.
module sram_ctrl #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 4,
    parameter int DEPTH     = 8,
    parameter int READ_LAT  = 1,
    parameter int INIT_ZERO = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W/8-1:0]   req_be,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  init_done
);
    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {INIT, IDLE, RD_WAIT, RSP} state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   init_cnt;
    logic [DATA_W-1:0]   rd_hold;
    logic                rd_err_hold;
    logic                accept;
    logic                oor;
    logic [IDX_W-1:0]    req_idx;
    logic [IDX_W-1:0]    init_idx;
    logic [DATA_W-1:0]   rd_word;

    assign accept   = req_valid && req_ready;
    assign oor      = {1'b0, req_addr} >= DEPTH_C;
    assign req_idx  = req_addr[IDX_W-1:0];
    assign init_idx = init_cnt[IDX_W-1:0];
    // Out-of-range reads never touch the array, so aliasing low address bits is harmless.
    assign rd_word  = oor ? '0 : mem[req_idx];

    // Array has no reset so its contents survive rst when zero-fill is disabled.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[init_idx] <= '0;
        end else if (accept && req_we && !oor) begin
            for (int i = 0; i < BE_W; i++) begin
                if (req_be[i]) begin
                    mem[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= (INIT_ZERO != 0) ? INIT : IDLE;
            init_cnt    <= '0;
            req_ready   <= 1'b0;
            init_done   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rd_hold     <= '0;
            rd_err_hold <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == LAST) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        init_done <= 1'b1;
                    end
                end
                IDLE: begin
                    init_done <= 1'b1;
                    req_ready <= 1'b1;
                    if (accept && !req_we) begin
                        req_ready <= 1'b0;
                        if (READ_LAT == 2) begin
                            state       <= RD_WAIT;
                            rd_hold     <= rd_word;
                            rd_err_hold <= oor;
                        end else begin
                            state     <= RSP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= rd_word;
                            rsp_err   <= oor;
                        end
                    end
                end
                RD_WAIT: begin
                    state     <= RSP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= rd_hold;
                    rsp_err   <= rd_err_hold;
                end
                RSP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: instance 0 uses defaults, instance 1 uses READ_LAT=2 and INIT_ZERO=0.
// Expected read results are queued when a read is issued and compared when the response appears.
module tb_sram_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [3:0]  req_addr  [2];
    logic [1:0]  req_be    [2];
    logic [15:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [15:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        init_done [2];

    sram_ctrl u0 (
        .clk(clk), .rst(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_be(req_be[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .init_done(init_done[0])
    );

    sram_ctrl #(.READ_LAT(2), .INIT_ZERO(0)) u1 (
        .clk(clk), .rst(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_be(req_be[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .init_done(init_done[1])
    );

    typedef struct packed {
        logic [15:0] d;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic wait_ready(input int d);
        int n = 0;
        while (req_ready[d] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (req_ready[d] !== 1'b1) begin
            bad++;
            $display("FAIL ready_timeout dev=%0d got=%b want=1", d, req_ready[d]);
        end
    endtask

    task automatic do_write(input int d, input logic [3:0] a, input logic [15:0] wd, input logic [1:0] be);
        wait_ready(d);
        req_valid[d] = 1'b1;
        req_we[d]    = 1'b1;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        req_be[d]    = be;
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_we[d]    = 1'b0;
    endtask

    // Returns one falling edge after the accept edge.
    task automatic send_read(input int d, input logic [3:0] a, input logic [15:0] ed, input logic ee);
        exp_t x;
        wait_ready(d);
        x.d = ed;
        x.e = ee;
        sb.push_back(x);
        req_valid[d] = 1'b1;
        req_we[d]    = 1'b0;
        req_addr[d]  = a;
        @(negedge clk);
        req_valid[d] = 1'b0;
    endtask

    task automatic get_rsp(input int d, input int exp_lat, input int hold);
        int   lat = 1;
        exp_t x;
        while (rsp_valid[d] !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat != exp_lat || rsp_valid[d] !== 1'b1) begin
            bad++;
            $display("FAIL rsp_latency dev=%0d got=%0d want=%0d", d, lat, exp_lat);
        end
        x = sb.pop_front();
        total++;
        if (rsp_rdata[d] !== x.d) begin
            bad++;
            $display("FAIL rsp_rdata dev=%0d got=%h want=%h", d, rsp_rdata[d], x.d);
        end
        total++;
        if (rsp_err[d] !== x.e) begin
            bad++;
            $display("FAIL rsp_err dev=%0d got=%b want=%b", d, rsp_err[d], x.e);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            total++;
            if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== x.d || req_ready[d] !== 1'b0) begin
                bad++;
                $display("FAIL hold_stable dev=%0d cyc=%0d got v=%b d=%h rdy=%b want v=1 d=%h rdy=0",
                         d, i, rsp_valid[d], rsp_rdata[d], req_ready[d], x.d);
            end
        end
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        total++;
        if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1 || rsp_rdata[d] !== 16'h0 || rsp_err[d] !== 1'b0) begin
            bad++;
            $display("FAIL rsp_release dev=%0d got v=%b rdy=%b d=%h e=%b want v=0 rdy=1 d=0000 e=0",
                     d, rsp_valid[d], req_ready[d], rsp_rdata[d], rsp_err[d]);
        end
    endtask

    task automatic test_reset();
        logic exp_id;
        #1;
        total++;
        if (req_ready[0] !== 1'b0 || init_done[0] !== 1'b0 || rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 16'h0) begin
            bad++;
            $display("FAIL reset_state got rdy=%b done=%b v=%b d=%h want 0 0 0 0000",
                     req_ready[0], init_done[0], rsp_valid[0], rsp_rdata[0]);
        end
        @(negedge clk);
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            exp_id = (i == 8);
            total++;
            if (init_done[0] !== exp_id || req_ready[0] !== exp_id) begin
                bad++;
                $display("FAIL init_fill edge=%0d got done=%b rdy=%b want %b", i, init_done[0], req_ready[0], exp_id);
            end
            total++;
            if (init_done[1] !== 1'b1 || req_ready[1] !== 1'b1) begin
                bad++;
                $display("FAIL noinit_ready edge=%0d got done=%b rdy=%b want 1", i, init_done[1], req_ready[1]);
            end
        end
        send_read(0, 4'd5, 16'h0000, 1'b0);
        get_rsp(0, 1, 0);
    endtask

    task automatic test_byte_en();
        do_write(0, 4'd3, 16'hA5C3, 2'b11);
        do_write(0, 4'd3, 16'h1200, 2'b10);
        send_read(0, 4'd3, 16'h12C3, 1'b0);
        get_rsp(0, 1, 0);
        do_write(0, 4'd3, 16'hFFFF, 2'b00);
        do_write(0, 4'd4, 16'h00AB, 2'b01);
        send_read(0, 4'd3, 16'h12C3, 1'b0);
        get_rsp(0, 1, 0);
        send_read(0, 4'd4, 16'h00AB, 1'b0);
        get_rsp(0, 1, 0);
    endtask

    task automatic test_out_of_range();
        do_write(0, 4'd9, 16'hFFFF, 2'b11);
        send_read(0, 4'd9, 16'h0000, 1'b1);
        get_rsp(0, 1, 0);
        send_read(0, 4'd7, 16'h0000, 1'b0);
        get_rsp(0, 1, 0);
        send_read(0, 4'd1, 16'h0000, 1'b0);
        get_rsp(0, 1, 0);
    endtask

    task automatic test_backpressure();
        do_write(0, 4'd2, 16'hBEEF, 2'b11);
        send_read(0, 4'd2, 16'hBEEF, 1'b0);
        get_rsp(0, 1, 5);
    endtask

    task automatic test_read_lat2();
        do_write(1, 4'd1, 16'h1234, 2'b11);
        send_read(1, 4'd1, 16'h1234, 1'b0);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_addr[1]  = 4'd1;
        req_wdata[1] = 16'h5678;
        req_be[1]    = 2'b11;
        get_rsp(1, 2, 0);
        req_valid[1] = 1'b0;
        req_we[1]    = 1'b0;
        send_read(1, 4'd1, 16'h1234, 1'b0);
        get_rsp(1, 2, 0);
    endtask

    task automatic test_reset_mid();
        exp_t dropped;
        do_write(1, 4'd2, 16'hBEEF, 2'b11);
        send_read(1, 4'd2, 16'hBEEF, 1'b0);
        @(negedge clk);
        total++;
        if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== 16'hBEEF) begin
            bad++;
            $display("FAIL pre_reset_rsp got v=%b d=%h want v=1 d=beef", rsp_valid[1], rsp_rdata[1]);
        end
        dropped = sb.pop_front();
        #2 rst[1] = 1'b1;
        #1;
        total++;
        if (rsp_valid[1] !== 1'b0 || rsp_rdata[1] !== 16'h0 || rsp_err[1] !== 1'b0 ||
            req_ready[1] !== 1'b0 || init_done[1] !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got v=%b d=%h e=%b rdy=%b done=%b want all 0 (dropped %h)",
                     rsp_valid[1], rsp_rdata[1], rsp_err[1], req_ready[1], init_done[1], dropped.d);
        end
        @(negedge clk);
        rst[1] = 1'b0;
        send_read(1, 4'd2, 16'hBEEF, 1'b0);
        get_rsp(1, 2, 0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d]       = 1'b1;
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = '0;
            req_be[d]    = '0;
            req_wdata[d] = '0;
            rsp_ready[d] = 1'b0;
        end
        test_reset();
        test_byte_en();
        test_out_of_range();
        test_backpressure();
        test_read_lat2();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
